// File: rtl/icmp_echo_reply_tx.sv
// -----------------------------------------------------------------------------
// icmp_echo_reply_tx
//
// Builds an ICMP echo reply from one already-validated 98-byte
// Ethernet/IPv4/ICMP echo-request frame (proto_frame_t layout, 784 bits,
// dst_mac in bits [783:736]) and streams it MSB-first, one byte per
// handshake, to the MAC TX path.
//
// Flow: IDLE -> CSUM (40 cycles, one 16-bit word per cycle) -> FOLD (1 cycle)
//       -> SEND (98 bytes) -> IDLE.
//
// Ports:
//   clk_i        clock
//   rst_ni       asynchronous active-low reset
//   mac_addr_i   local MAC, sampled on request accept
//   ip_addr_i    local IPv4 address, sampled on request accept
//   req_valid_i  request frame valid
//   req_ready_o  block can accept a request (high only in IDLE)
//   req_frame_i  request frame
//   tx_data_o    reply byte
//   tx_valid_o   tx_data_o valid (high throughout SEND)
//   tx_ready_i   sink accepts byte
//   tx_last_o    final byte (byte 97) of the reply
//   busy_o       high in any state other than IDLE
//   reply_cnt_o  completed replies, wraps at 0xFFFF -> 0
// -----------------------------------------------------------------------------
module icmp_echo_reply_tx #(
  parameter logic [7:0]  P_TTL        = 8'h40,
  parameter logic [15:0] P_IP_ID_INIT = 16'h0000
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [47:0]  mac_addr_i,
  input  logic [31:0]  ip_addr_i,
  input  logic         req_valid_i,
  output logic         req_ready_o,
  input  logic [783:0] req_frame_i,
  output logic [7:0]   tx_data_o,
  output logic         tx_valid_o,
  input  logic         tx_ready_i,
  output logic         tx_last_o,
  output logic         busy_o,
  output logic [15:0]  reply_cnt_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CSUM = 2'd1,
    FOLD = 2'd2,
    SEND = 2'd3
  } state_t;

  state_t state_q, state_nxt;

  logic [783:0] frame_q;
  logic [31:0]  ip_acc_q;
  logic [31:0]  icmp_acc_q;
  logic [5:0]   k_q;
  logic [6:0]   b_q;
  logic [15:0]  ip_id_q;
  logic [15:0]  reply_cnt_q;

  logic         accept;
  logic         tx_hs;
  logic         last_hs;
  logic [9:0]   word_off;
  logic [15:0]  csum_word;
  logic [783:0] reply_frame;

  // Fields of the request that the reply never uses.
  logic unused_req_bits;
  assign unused_req_bits = ^{req_frame_i[783:736], req_frame_i[687:664],
                             req_frame_i[639:576], req_frame_i[543:480]};

  // Two end-around-carry folds, then one's complement.
  function automatic logic [15:0] fold_csum(input logic [31:0] s);
    logic [31:0] t1;
    logic [31:0] t2;
    t1 = {16'h0000, s[15:0]} + {16'h0000, s[31:16]};
    t2 = {16'h0000, t1[15:0]} + {16'h0000, t1[31:16]};
    return ~t2[15:0];
  endfunction

  assign accept  = req_valid_i && (state_q == IDLE);
  assign tx_hs   = (state_q == SEND) && tx_ready_i;
  assign last_hs = tx_hs && (b_q == 7'd97);

  // Reply frame as assembled at accept; both checksum fields start at zero
  // so the CSUM walk can treat the frame register as its only source.
  assign reply_frame = {req_frame_i[735:688],            // dst_mac = req.src_mac
                        mac_addr_i,                      // src_mac
                        16'h0800,                        // ethertype
                        4'h4, 4'h5,                      // version, ihl
                        req_frame_i[663:656],            // tos
                        req_frame_i[655:640],            // ip_length
                        ip_id_q,                         // ip_id
                        3'b010, 13'd0,                   // flags, frag_off
                        P_TTL, 8'h01,                    // ttl, protocol
                        16'h0000,                        // ip checksum
                        ip_addr_i,                       // ip_src
                        req_frame_i[575:544],            // ip_dst = req.ip_src
                        8'h00, 8'h00,                    // icmp type, code
                        16'h0000,                        // icmp checksum
                        req_frame_i[479:0]};             // id, seq, data

  // Bit offset of the word summed at step k. The IP checksum word (591) is
  // skipped between k=4 and k=5; the ICMP checksum word (495) between k=9
  // and k=10. From k=10 on, id, seq and data are contiguous.
  always_comb begin
    logic [9:0] k_ext;
    k_ext = {4'd0, k_q};
    if (k_q < 6'd5) begin
      word_off = 10'd671 - (k_ext << 4);
    end else if (k_q < 6'd9) begin
      word_off = 10'd655 - (k_ext << 4);
    end else if (k_q == 6'd9) begin
      word_off = 10'd511;
    end else begin
      word_off = 10'd639 - (k_ext << 4);
    end
  end

  assign csum_word = frame_q[word_off -: 16];

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE:    if (accept)        state_nxt = CSUM;
      CSUM:    if (k_q == 6'd39)  state_nxt = FOLD;
      FOLD:                       state_nxt = SEND;
      SEND:    if (last_hs)       state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      k_q         <= 6'd0;
      b_q         <= 7'd0;
      ip_id_q     <= P_IP_ID_INIT;
      reply_cnt_q <= 16'h0000;
    end else begin
      state_q <= state_nxt;
      if (accept) begin
        k_q <= 6'd0;
      end else if ((state_q == CSUM) && (k_q != 6'd39)) begin
        k_q <= k_q + 6'd1;
      end
      if (state_q == FOLD) begin
        b_q <= 7'd0;
      end else if (tx_hs) begin
        b_q <= b_q + 7'd1;
      end
      if (last_hs) begin
        reply_cnt_q <= reply_cnt_q + 16'h0001;
        ip_id_q     <= ip_id_q + 16'h0001;
      end
    end
  end

  // ---- datapath: frame register and accumulators (no reset needed) ----
  always_ff @(posedge clk_i) begin
    case (state_q)
      IDLE: begin
        if (accept) begin
          frame_q    <= reply_frame;
          ip_acc_q   <= 32'h0;
          icmp_acc_q <= 32'h0;
        end
      end
      CSUM: begin
        if (k_q < 6'd9) begin
          ip_acc_q <= ip_acc_q + {16'h0000, csum_word};
        end else begin
          icmp_acc_q <= icmp_acc_q + {16'h0000, csum_word};
        end
      end
      FOLD: begin
        frame_q[591:576] <= fold_csum(ip_acc_q);
        frame_q[495:480] <= fold_csum(icmp_acc_q);
      end
      SEND: begin
        // The current byte always sits in the top 8 bits.
        if (tx_ready_i) begin
          frame_q <= {frame_q[775:0], 8'h00};
        end
      end
      default: ;
    endcase
  end

  assign req_ready_o = (state_q == IDLE);
  assign busy_o      = (state_q != IDLE);
  assign tx_valid_o  = (state_q == SEND);
  assign tx_last_o   = (state_q == SEND) && (b_q == 7'd97);
  assign tx_data_o   = (state_q == SEND) ? frame_q[783:776] : 8'h00;
  assign reply_cnt_o = reply_cnt_q;

endmodule

// File: tb/tb_icmp_echo_reply_tx.sv
module tb_icmp_echo_reply_tx;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [47:0]  mac_addr;
  logic [31:0]  ip_addr;
  logic         req_valid;
  logic [783:0] req_frame;
  logic         tx_ready;

  logic         req_ready_a, tx_valid_a, tx_last_a, busy_a;
  logic [7:0]   tx_data_a;
  logic [15:0]  reply_cnt_a;
  logic         req_ready_b, tx_valid_b, tx_last_b, busy_b;
  logic [7:0]   tx_data_b;
  logic [15:0]  reply_cnt_b;

  always #5 clk = ~clk;

  icmp_echo_reply_tx #(.P_TTL(8'h40), .P_IP_ID_INIT(16'h0000)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .mac_addr_i(mac_addr), .ip_addr_i(ip_addr),
    .req_valid_i(req_valid), .req_ready_o(req_ready_a), .req_frame_i(req_frame),
    .tx_data_o(tx_data_a), .tx_valid_o(tx_valid_a), .tx_ready_i(tx_ready),
    .tx_last_o(tx_last_a), .busy_o(busy_a), .reply_cnt_o(reply_cnt_a));

  // Same inputs, ID counter starting at 0xFFFF; used for the wrap case.
  icmp_echo_reply_tx #(.P_TTL(8'h40), .P_IP_ID_INIT(16'hFFFF)) u_dut_wrap (
    .clk_i(clk), .rst_ni(rst_n), .mac_addr_i(mac_addr), .ip_addr_i(ip_addr),
    .req_valid_i(req_valid), .req_ready_o(req_ready_b), .req_frame_i(req_frame),
    .tx_data_o(tx_data_b), .tx_valid_o(tx_valid_b), .tx_ready_i(tx_ready),
    .tx_last_o(tx_last_b), .busy_o(busy_b), .reply_cnt_o(reply_cnt_b));

  logic       mon_sel;
  logic [7:0] m_data;
  logic       m_valid, m_last, m_ready_req;
  assign m_data      = mon_sel ? tx_data_b   : tx_data_a;
  assign m_valid     = mon_sel ? tx_valid_b  : tx_valid_a;
  assign m_last      = mon_sel ? tx_last_b   : tx_last_a;
  assign m_ready_req = mon_sel ? req_ready_b : req_ready_a;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [7:0] rx    [0:97];
  logic [7:0] exp_b [0:97];
  int rx_n, rx_last_n, rx_last_bad, rx_unstable, rx_first_cyc, rx_rdy_hi;

  function automatic logic [783:0] mk_req(input logic [47:0] src_mac, input logic [31:0] ip_src,
                                          input logic [15:0] len, input logic [7:0] tos,
                                          input logic [15:0] id, input logic [15:0] seq,
                                          input logic [7:0] seed);
    logic [783:0] f;
    logic [7:0]   b [0:97];
    for (int i = 0; i < 6; i++) b[i] = 8'hA0 + 8'(i);
    for (int i = 0; i < 6; i++) b[6+i] = src_mac[47-8*i -: 8];
    b[12] = 8'h08; b[13] = 8'h00; b[14] = 8'h45; b[15] = tos;
    b[16] = len[15:8]; b[17] = len[7:0];
    b[18] = 8'hBE; b[19] = 8'hEF; b[20] = 8'h40; b[21] = 8'h00;
    b[22] = 8'h37; b[23] = 8'h01; b[24] = 8'h12; b[25] = 8'h34;
    for (int i = 0; i < 4; i++) b[26+i] = ip_src[31-8*i -: 8];
    b[30] = 8'hC0; b[31] = 8'hA8; b[32] = 8'h00; b[33] = 8'h02;
    b[34] = 8'h08; b[35] = 8'h00; b[36] = 8'h5A; b[37] = 8'h5A;
    b[38] = id[15:8]; b[39] = id[7:0]; b[40] = seq[15:8]; b[41] = seq[7:0];
    for (int i = 42; i < 98; i++) b[i] = (seed == 8'h00) ? 8'h00 : 8'(i * seed);
    for (int i = 0; i < 98; i++) f[783-8*i -: 8] = b[i];
    return f;
  endfunction

  function automatic logic [15:0] ones_csum(input int lo, input int hi);
    logic [31:0] s;
    s = 32'h0;
    for (int i = lo; i <= hi; i += 2) s = s + {16'h0, exp_b[i], exp_b[i+1]};
    while (s[31:16] != 16'h0) s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
    return ~s[15:0];
  endfunction

  // Reference reply, byte by byte, from the request's byte view.
  task automatic build_expected(input logic [783:0] req, input logic [47:0] mac,
                                input logic [31:0] ip, input logic [15:0] id);
    logic [7:0]  rb [0:97];
    logic [15:0] c;
    for (int i = 0; i < 98; i++) rb[i] = req[783-8*i -: 8];
    for (int i = 0; i < 6; i++) exp_b[i] = rb[6+i];
    for (int i = 0; i < 6; i++) exp_b[6+i] = mac[47-8*i -: 8];
    exp_b[12] = 8'h08; exp_b[13] = 8'h00; exp_b[14] = 8'h45;
    exp_b[15] = rb[15]; exp_b[16] = rb[16]; exp_b[17] = rb[17];
    exp_b[18] = id[15:8]; exp_b[19] = id[7:0];
    exp_b[20] = 8'h40; exp_b[21] = 8'h00; exp_b[22] = 8'h40; exp_b[23] = 8'h01;
    exp_b[24] = 8'h00; exp_b[25] = 8'h00;
    for (int i = 0; i < 4; i++) exp_b[26+i] = ip[31-8*i -: 8];
    for (int i = 0; i < 4; i++) exp_b[30+i] = rb[26+i];
    exp_b[34] = 8'h00; exp_b[35] = 8'h00; exp_b[36] = 8'h00; exp_b[37] = 8'h00;
    for (int i = 38; i < 98; i++) exp_b[i] = rb[i];
    c = ones_csum(14, 33); exp_b[24] = c[15:8]; exp_b[25] = c[7:0];
    c = ones_csum(34, 97); exp_b[36] = c[15:8]; exp_b[37] = c[7:0];
  endtask

  task automatic do_req(input logic [783:0] f, input bit hold, output int acc_cyc);
    bit got;
    got = 0;
    acc_cyc = -1;
    @(negedge clk);
    req_frame = f;
    req_valid = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (m_ready_req) begin
        got = 1;
        acc_cyc = cyc;
        break;
      end
      @(negedge clk);
    end
    if (!got) chk("req_accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    if (!hold) req_valid = 1'b0;
  endtask

  // Collects one reply; returns early (ok=1) when byte abort_at is presented.
  task automatic rx_reply(input bit randstall, input int abort_at, output bit ok);
    int         idx;
    bit         prev_stall;
    logic [7:0] prev_d;
    idx = 0; prev_stall = 0; prev_d = 8'h00; ok = 0;
    rx_n = 0; rx_last_n = 0; rx_last_bad = 0; rx_unstable = 0;
    rx_first_cyc = -1; rx_rdy_hi = 0;
    for (int t = 0; t < 2000 && idx < 98; t++) begin
      @(negedge clk);
      if (m_valid && rx_first_cyc < 0) rx_first_cyc = cyc;
      if (abort_at >= 0 && m_valid && idx == abort_at) begin
        ok = 1;
        rx_n = idx;
        return;
      end
      if (prev_stall && m_data !== prev_d) rx_unstable++;
      tx_ready = randstall ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (m_valid) begin
        if (m_ready_req) rx_rdy_hi++;
        if (m_last !== (idx == 97)) rx_last_bad++;
        if (tx_ready) begin
          if (m_last) rx_last_n++;
          rx[idx] = m_data;
          idx++;
          prev_stall = 0;
        end else begin
          prev_stall = 1;
          prev_d = m_data;
        end
      end else begin
        prev_stall = 0;
      end
    end
    rx_n = idx;
    ok = (idx == 98);
    if (!ok) chk("reply_timeout", 64'(idx), 64'd98);
  endtask

  task automatic chk_bytes(input string p);
    int nmis;
    nmis = 0;
    for (int i = 0; i < 98; i++) if (rx[i] !== exp_b[i]) nmis++;
    chk({p, "_nbytes"}, 64'(rx_n), 64'd98);
    chk({p, "_byte_mismatches"}, 64'(nmis), 64'd0);
    chk({p, "_last_count"}, 64'(rx_last_n), 64'd1);
    chk({p, "_last_misplaced"}, 64'(rx_last_bad), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tx_ready = 1'b1;
  endtask

  logic [783:0] f_nom, f_zero, f_bp;
  int acc;
  bit ok;

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_frame = '0; tx_ready = 1'b1; mon_sel = 1'b0;
    mac_addr = 48'h02_11_22_33_44_55;
    ip_addr  = 32'hC0A80002;
    f_nom  = mk_req(48'h00_1B_21_AA_BB_CC, 32'hC0A80001, 16'h0054, 8'h00, 16'h1234, 16'h0001, 8'h00);
    f_zero = mk_req(48'h00_1B_21_AA_BB_CC, 32'hC0A80001, 16'h0054, 8'h00, 16'h0000, 16'h0000, 8'h00);
    f_bp   = mk_req(48'h3C_FD_FE_01_02_03, 32'h0A000017, 16'h0054, 8'h10, 16'hBEAD, 16'h0042, 8'h1D);
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_req_ready", 64'(req_ready_a), 64'd1);
    chk("rst_tx_valid",  64'(tx_valid_a),  64'd0);
    chk("rst_tx_last",   64'(tx_last_a),   64'd0);
    chk("rst_tx_data",   64'(tx_data_a),   64'd0);
    chk("rst_busy",      64'(busy_a),      64'd0);
    chk("rst_reply_cnt", 64'(reply_cnt_a), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Nominal reply
    do_req(f_nom, 1'b0, acc);
    rx_reply(1'b0, -1, ok);
    chk("nom_latency",   64'(rx_first_cyc - acc), 64'd42);
    chk("nom_ip_csum",   {48'h0, rx[24], rx[25]}, 64'h B955);
    chk("nom_icmp_csum", {48'h0, rx[36], rx[37]}, 64'h EDCA);
    chk("nom_icmp_type", 64'(rx[34]), 64'h00);
    chk("nom_dst_mac",   {16'h0, rx[0], rx[1], rx[2], rx[3], rx[4], rx[5]}, 64'h00_1B_21_AA_BB_CC);
    chk("nom_ip_id",     {48'h0, rx[18], rx[19]}, 64'h0000);
    build_expected(f_nom, mac_addr, ip_addr, 16'h0000);
    chk_bytes("nom");
    repeat (2) @(negedge clk);
    chk("nom_reply_cnt", 64'(reply_cnt_a), 64'd1);

    // Zero-sum ICMP
    do_req(f_zero, 1'b0, acc);
    rx_reply(1'b0, -1, ok);
    chk("zero_icmp_csum", {48'h0, rx[36], rx[37]}, 64'hFFFF);
    chk("zero_ip_id",     {48'h0, rx[18], rx[19]}, 64'h0001);

    // Back-pressure
    do_req(f_bp, 1'b0, acc);
    rx_reply(1'b1, -1, ok);
    tx_ready = 1'b1;
    chk("bp_stall_stable", 64'(rx_unstable), 64'd0);
    build_expected(f_bp, mac_addr, ip_addr, 16'h0002);
    chk_bytes("bp");

    // Back-to-back with req_valid held
    do_reset();
    do_req(f_nom, 1'b1, acc);
    rx_reply(1'b0, -1, ok);
    chk("b2b_ready_while_busy", 64'(rx_rdy_hi), 64'd0);
    chk("b2b_first_ip_id", {48'h0, rx[18], rx[19]}, 64'h0000);
    @(negedge clk);
    chk("b2b_ready_after_last", 64'(req_ready_a), 64'd1);
    @(posedge clk);
    #1;
    chk("b2b_second_accepted", 64'(busy_a), 64'd1);
    req_valid = 1'b0;
    rx_reply(1'b0, -1, ok);
    chk("b2b_second_ip_id", {48'h0, rx[18], rx[19]}, 64'h0001);
    build_expected(f_nom, mac_addr, ip_addr, 16'h0001);
    chk_bytes("b2b2");
    repeat (2) @(negedge clk);
    chk("b2b_reply_cnt", 64'(reply_cnt_a), 64'd2);

    // Reset at SEND byte 50
    do_req(f_bp, 1'b0, acc);
    rx_reply(1'b0, 50, ok);
    chk("abort_reached", 64'(ok), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_tx_valid",  64'(tx_valid_a),  64'd0);
    chk("abort_tx_last",   64'(tx_last_a),   64'd0);
    chk("abort_tx_data",   64'(tx_data_a),   64'd0);
    chk("abort_req_ready", 64'(req_ready_a), 64'd1);
    chk("abort_busy",      64'(busy_a),      64'd0);
    chk("abort_reply_cnt", 64'(reply_cnt_a), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_req(f_bp, 1'b0, acc);
    rx_reply(1'b0, -1, ok);
    chk("post_abort_ip_id", {48'h0, rx[18], rx[19]}, 64'h0000);
    build_expected(f_bp, mac_addr, ip_addr, 16'h0000);
    chk_bytes("post_abort");

    // ID counter wrap (instance starting at 0xFFFF)
    do_reset();
    mon_sel = 1'b1;
    do_req(f_nom, 1'b0, acc);
    rx_reply(1'b0, -1, ok);
    chk("wrap1_ip_id", {48'h0, rx[18], rx[19]}, 64'hFFFF);
    chk("wrap1_ip_csum", {48'h0, rx[24], rx[25]}, 64'hB955);
    build_expected(f_nom, mac_addr, ip_addr, 16'hFFFF);
    chk_bytes("wrap1");
    do_req(f_nom, 1'b0, acc);
    rx_reply(1'b0, -1, ok);
    chk("wrap2_ip_id", {48'h0, rx[18], rx[19]}, 64'h0000);
    build_expected(f_nom, mac_addr, ip_addr, 16'h0000);
    chk_bytes("wrap2");
    repeat (2) @(negedge clk);
    chk("wrap_reply_cnt", 64'(reply_cnt_b), 64'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
